// File: rtl/seg_display_scanner_if.sv
// Bundle of the value/control inputs and the pin-side outputs of the
// seven-segment scanner; master drives values, slave is the scanner.
interface seg_display_scanner_if #(
    parameter int NUM_DIGITS  = 8,
    parameter int BRIGHT_BITS = 4
);
    logic [4*NUM_DIGITS-1:0] val_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lz_suppress_in;
    logic [BRIGHT_BITS-1:0]  brightness_in;
    logic                    load_in;
    logic [6:0]              cat_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_out;

    modport master (
        output val_in, dp_in, blank_in, lz_suppress_in, brightness_in, load_in,
        input  cat_out, dp_out, an_out, frame_out
    );

    modport slave (
        input  val_in, dp_in, blank_in, lz_suppress_in, brightness_in, load_in,
        output cat_out, dp_out, an_out, frame_out
    );
endinterface

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered
// values, per-digit dp/blank, leading-zero suppression and PWM dimming.
module seg_display_scanner #(
    parameter int NUM_DIGITS  = 8,
    parameter int COUNT_TO    = 100_000,
    parameter int BRIGHT_BITS = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    seg_display_scanner_if.slave  bus
);
    localparam int CNT_W = (COUNT_TO > 1) ? $clog2(COUNT_TO) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLICE = COUNT_TO / (2 ** BRIGHT_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_TO - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Hex nibble to active-low cathode pattern (g..a, bit 0 = a).
    function automatic logic [6:0] hex_to_cat(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return ~seg;
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [BRIGHT_BITS-1:0]  bright_q, bright_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              cat_q, cat_d;
    logic                    dp_q, dp_d;
    logic                    frame_q, frame_d;

    logic                    last_cnt_s, wrap_s;
    logic [4*NUM_DIGITS-1:0] hi_val_s;
    logic [3:0]              nib_s;
    logic                    blank_s, dp_bit_s, supp_s, on_s;
    logic [31:0]             thr_s;

    // Dwell/digit scan, tear-free value buffering and brightness sampling.
    always_comb begin
        last_cnt_s   = (cnt_q == CNT_LAST);
        wrap_s       = last_cnt_s && (idx_q == IDX_LAST);
        cnt_d        = last_cnt_s ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
        idx_d        = last_cnt_s ? ((idx_q == IDX_LAST) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1)) : idx_q;
        bright_d     = (cnt_q == {CNT_W{1'b0}}) ? bus.brightness_in : bright_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        // A load landing on the wrap cycle bypasses pending entirely.
        if (bus.load_in && wrap_s) begin
            act_val_d    = bus.val_in;
            act_dp_d     = bus.dp_in;
            act_blank_d  = bus.blank_in;
            pend_valid_d = 1'b0;
        end else if (wrap_s && pend_valid_q) begin
            act_val_d    = pend_val_q;
            act_dp_d     = pend_dp_q;
            act_blank_d  = pend_blank_q;
            pend_valid_d = 1'b0;
        end else if (bus.load_in) begin
            pend_val_d   = bus.val_in;
            pend_dp_d    = bus.dp_in;
            pend_blank_d = bus.blank_in;
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // Pin values for the digit currently selected by idx/cnt.
    always_comb begin
        hi_val_s = act_val_q >> {idx_q, 2'b00};
        nib_s    = hi_val_s[3:0];
        blank_s  = act_blank_q[idx_q];
        dp_bit_s = act_dp_q[idx_q];
        supp_s   = bus.lz_suppress_in && (idx_q != {IDX_W{1'b0}}) && (hi_val_s == {(4*NUM_DIGITS){1'b0}});
        thr_s    = 32'(SLICE) * (32'(bright_q) + 32'd1);
        on_s     = !blank_s && (32'(cnt_q) < thr_s);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = !(on_s && (idx_q == IDX_W'(i)));
        end
        cat_d    = (blank_s || supp_s) ? 7'h7F : hex_to_cat(nib_s);
        dp_d     = blank_s ? 1'b1 : !dp_bit_s;
        frame_d  = wrap_s;
    end

    // State and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q        <= {CNT_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            pend_val_q   <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_q    <= {NUM_DIGITS{1'b0}};
            pend_blank_q <= {NUM_DIGITS{1'b0}};
            pend_valid_q <= 1'b0;
            act_val_q    <= {(4*NUM_DIGITS){1'b0}};
            act_dp_q     <= {NUM_DIGITS{1'b0}};
            act_blank_q  <= {NUM_DIGITS{1'b0}};
            bright_q     <= {BRIGHT_BITS{1'b0}};
            an_q         <= {NUM_DIGITS{1'b1}};
            cat_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            bright_q     <= bright_d;
            an_q         <= an_d;
            cat_q        <= cat_d;
            dp_q         <= dp_d;
            frame_q      <= frame_d;
        end
    end

    assign bus.an_out    = an_q;
    assign bus.cat_out   = cat_q;
    assign bus.dp_out    = dp_q;
    assign bus.frame_out = frame_q;
endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench: stimulus queues cycle-stamped expected pin states,
// a negedge monitor pops and compares them against the scanner outputs.
module tb_seg_display_scanner;
    localparam int ND = 4;
    localparam int CT = 16;
    localparam int BB = 2;

    logic clk_in = 1'b0;
    logic rst_in;

    seg_display_scanner_if #(.NUM_DIGITS(ND), .BRIGHT_BITS(BB)) bus ();

    seg_display_scanner #(.NUM_DIGITS(ND), .COUNT_TO(CT), .BRIGHT_BITS(BB)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] cat;
        logic       dp;
        logic       fr;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Posedges since the last reset release; entries with cyc = -1 are checked while in reset.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk_in) begin
        if (exp_q.size() > 0 && (rst_in ? (exp_q[0].cyc < 0) : (exp_q[0].cyc <= cyc))) begin
            n_tests <= n_tests + 1;
            if (!rst_in && exp_q[0].cyc != cyc) begin
                n_fail <= n_fail + 1;
                $display("FAIL missed_check: checked at cyc %0d, required cyc %0d", cyc, exp_q[0].cyc);
            end else if ({bus.an_out, bus.cat_out, bus.dp_out, bus.frame_out} !==
                         {exp_q[0].an, exp_q[0].cat, exp_q[0].dp, exp_q[0].fr}) begin
                n_fail <= n_fail + 1;
                $display("FAIL pins_cyc%0d: got an=%h cat=%h dp=%b frame=%b, expected an=%h cat=%h dp=%b frame=%b",
                         exp_q[0].cyc, bus.an_out, bus.cat_out, bus.dp_out, bus.frame_out,
                         exp_q[0].an, exp_q[0].cat, exp_q[0].dp, exp_q[0].fr);
            end
            exp_q.delete(0);
        end
    end

    task automatic expect_at(input int c, input logic [3:0] an, input logic [6:0] cat,
                             input logic dp, input logic fr);
        exp_t e;
        e.cyc = c; e.an = an; e.cat = cat; e.dp = dp; e.fr = fr;
        exp_q.push_back(e);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Presents a value set so that load_in is sampled on posedge p.
    task automatic load_at(input int p, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        go_to(p - 1);
        bus.val_in   = v;
        bus.dp_in    = dp;
        bus.blank_in = bl;
        bus.load_in  = 1'b1;
        go_to(p);
        bus.load_in  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in             = 1'b1;
        bus.val_in         = 16'h0000;
        bus.dp_in          = 4'b0000;
        bus.blank_in       = 4'b0000;
        bus.lz_suppress_in = 1'b0;
        bus.brightness_in  = 2'd3;
        bus.load_in        = 1'b0;
        expect_at(-1, 4'hF, 7'h7F, 1'b1, 1'b0);
        #22;
        @(negedge clk_in);
        rst_in = 1'b0;

        // Frames 0..8: outputs after posedge 64n+1..64n+64 belong to frame n.
        expect_at(1,   4'hE, 7'h40, 1'b1, 1'b0);
        expect_at(60,  4'h7, 7'h40, 1'b1, 1'b0);
        expect_at(63,  4'h7, 7'h40, 1'b1, 1'b0);
        expect_at(64,  4'h7, 7'h40, 1'b1, 1'b1);
        expect_at(65,  4'hE, 7'h19, 1'b1, 1'b0);
        expect_at(80,  4'hE, 7'h19, 1'b1, 1'b0);
        expect_at(81,  4'hD, 7'h30, 1'b1, 1'b0);
        expect_at(97,  4'hB, 7'h24, 1'b1, 1'b0);
        expect_at(113, 4'h7, 7'h79, 1'b1, 1'b0);
        expect_at(129, 4'hE, 7'h19, 1'b1, 1'b0);
        expect_at(193, 4'hE, 7'h12, 1'b1, 1'b0);
        expect_at(209, 4'hD, 7'h7F, 1'b1, 1'b0);
        expect_at(241, 4'h7, 7'h7F, 1'b1, 1'b0);
        expect_at(257, 4'hE, 7'h40, 1'b1, 1'b0);
        expect_at(273, 4'hD, 7'h7F, 1'b1, 1'b0);
        expect_at(303, 4'hB, 7'h7F, 1'b1, 1'b0);
        expect_at(312, 4'h7, 7'h7F, 1'b1, 1'b0);
        expect_at(313, 4'hF, 7'h7F, 1'b1, 1'b0);
        expect_at(320, 4'hF, 7'h7F, 1'b1, 1'b1);
        expect_at(321, 4'hE, 7'h40, 1'b1, 1'b0);
        expect_at(329, 4'hF, 7'h40, 1'b1, 1'b0);
        expect_at(360, 4'hB, 7'h40, 1'b1, 1'b0);
        expect_at(384, 4'hF, 7'h40, 1'b1, 1'b1);
        expect_at(385, 4'hE, 7'h03, 1'b1, 1'b0);
        expect_at(401, 4'hD, 7'h03, 1'b1, 1'b0);
        expect_at(409, 4'hF, 7'h03, 1'b1, 1'b0);
        expect_at(448, 4'hF, 7'h03, 1'b1, 1'b1);
        expect_at(449, 4'hE, 7'h46, 1'b0, 1'b0);
        expect_at(465, 4'hF, 7'h7F, 1'b1, 1'b0);
        expect_at(469, 4'hF, 7'h7F, 1'b1, 1'b0);
        expect_at(481, 4'hB, 7'h46, 1'b1, 1'b0);
        expect_at(489, 4'hB, 7'h46, 1'b1, 1'b0);
        expect_at(497, 4'h7, 7'h46, 1'b1, 1'b0);
        expect_at(512, 4'h7, 7'h46, 1'b1, 1'b1);
        expect_at(513, 4'hE, 7'h46, 1'b0, 1'b0);

        load_at(10, 16'h1234, 4'b0000, 4'b0000);
        load_at(130, 16'h0005, 4'b0000, 4'b0000);
        bus.lz_suppress_in = 1'b1;
        load_at(200, 16'h0000, 4'b0000, 4'b0000);
        go_to(300);
        bus.brightness_in = 2'd1;
        go_to(322);
        bus.lz_suppress_in = 1'b0;
        load_at(330, 16'hAAAA, 4'b0000, 4'b0000);
        load_at(350, 16'hBBBB, 4'b0000, 4'b0000);
        load_at(448, 16'hCCCC, 4'b0011, 4'b0010);
        bus.brightness_in = 2'd3;
        load_at(521, 16'h9999, 4'b0000, 4'b0000);

        // Asynchronous reset mid-dwell with a load still pending.
        go_to(530);
        expect_at(-1, 4'hF, 7'h7F, 1'b1, 1'b0);
        #3;
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        expect_at(1,  4'hE, 7'h40, 1'b1, 1'b0);
        expect_at(17, 4'hD, 7'h40, 1'b1, 1'b0);
        expect_at(64, 4'h7, 7'h40, 1'b1, 1'b1);
        expect_at(65, 4'hE, 7'h40, 1'b1, 1'b0);
        expect_at(81, 4'hD, 7'h40, 1'b1, 1'b0);
        go_to(90);
        @(posedge clk_in);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Parametrised, time-multiplexed driver for common-anode seven-segment banks with NUM_DIGITS digits. Adds per-digit decimal point and blanking, leading-zero suppression, PWM brightness, and tear-free double-buffered value loading. It sits between any value-producing logic and the board's cathode/anode pins, and supersedes the fixed 8-digit hex scanner.

## Interface
- NUM_DIGITS, 8: digits scanned, 1..16
- COUNT_TO, 100_000: clock cycles each digit is selected (dwell)
  - must be a multiple of 2**BRIGHT_BITS
  - must be ≥ 2**BRIGHT_BITS
- BRIGHT_BITS, 4: brightness resolution in bits, 1..8
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- val_in  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i
- dp_in  in  NUM_DIGITS  decimal point enable per digit, 1 = lit
- blank_in  in  NUM_DIGITS  per-digit force-off, 1 = blank
- lz_suppress_in  in  1  enable leading-zero suppression
- brightness_in  in  BRIGHT_BITS  duty level, 0 = dimmest, all-ones = 100%
- load_in  in  1  single-cycle strobe; capture val_in, dp_in, blank_in
- cat_out  out  7  segments g..a (bit 0 = a), active-low
- dp_out  out  1  decimal point, active-low
- an_out  out  NUM_DIGITS  digit selects, active-low, one-cold or all-ones
- frame_out  out  1  one-cycle pulse at each scan wrap

## Operation
- Registers:
  - dwell counter cnt, range 0..COUNT_TO-1
  - digit index idx, range 0..NUM_DIGITS-1
  - pending {val, dp, blank} and pend_valid
  - active {val, dp, blank}
  - brightness_q
  - registered outputs
- Scan:
  - cnt increments every cycle.
  - When cnt == COUNT_TO-1: cnt <= 0, and idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
- Loading:
  - load_in captures the inputs into pending and sets pend_valid.
  - On the wrap cycle (cnt == COUNT_TO-1 and idx == NUM_DIGITS-1) with pend_valid set: active <= pending, pend_valid <= 0.
  - If load_in coincides with the wrap cycle, the load_in data goes directly to active and pend_valid ends 0.
  - A second load before the wrap overwrites pending; the last load wins.
  - Active never changes mid-frame.
- Brightness:
  - brightness_q <= brightness_in whenever cnt == 0.
  - slice = COUNT_TO / 2**BRIGHT_BITS.
  - The digit anode is enabled while cnt < slice*(brightness_q+1); otherwise an_out is all ones.
- Leading-zero suppression: when lz_suppress_in = 1, digit i > 0 is suppressed if active nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed.
  - A suppressed digit drives cat_out = 7'h7F.
  - Its anode and dp_out still follow the normal rules.
- Blanking: blank bit set -> an_out all ones for that dwell. Overrides dp, suppression and PWM.
- Decode: standard hex, segments lit (active-high, g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - cat_out is the bitwise inverse.
- frame_out = 1 for exactly the cycle after the wrap cycle, concurrent with active showing the new frame.

## Timing
- All outputs are registered: each reflects the cnt/idx/active state of the previous cycle (1-cycle latency).
- Reset values, asserted asynchronously and held while rst_in = 1:
  - cnt = 0, idx = 0
  - active and pending all zero, pend_valid = 0
  - brightness_q = 0
  - an_out all ones, cat_out = 7'h7F, dp_out = 1, frame_out = 0
- First cycle after release: cnt = 0 samples brightness_in; outputs show digit 0 from the next edge.
- Reset mid-frame discards pending data; the display resumes at digit 0 with active = 0.
- Full scan period = NUM_DIGITS*COUNT_TO cycles. frame_out period is identical.
- load_in on reset-release edge is ignored (reset dominates).

## Test plan
- NUM_DIGITS=4, COUNT_TO=16, BRIGHT_BITS=2, brightness 3, load val 0x1234 -> after next frame_out, an_out cycles E,D,B,7 with 16 cycles each; cat_out shows 4,3,2,1 (7'h19, 7'h30, 7'h24, 7'h79).
- Same config, load 0x0005, lz_suppress_in=1 -> digit 0 cat_out 7'h12; digits 1–3 cat_out 7'h7F. Load 0x0000 -> digit 0 shows 7'h40.
- brightness_in=1, slice=4 -> each digit's anode is low for cnt 0..7 and high for cnt 8..15. Change brightness mid-dwell -> takes effect at the next cnt=0.
- Load 0xAAAA mid-frame, then 0xBBBB before wrap -> display keeps old value until wrap, then shows b on all digits. Load exactly on wrap cycle -> new value in the next frame, pend_valid 0.
- blank_in=4'b0010, dp_in=4'b0011 -> digit 1 anode never low; digit 0 dp_out=0. Assert rst_in mid-dwell -> an_out all ones immediately without waiting for a clock edge; after release, pending data is lost.
